// File: rtl/garage_gate_controller.sv
`default_nettype none
// ============================================================================
// Module   : garage_gate_controller
// Brief    : Single-lane car-park gate sequencer with BCD free-space counter.
// Revision : 1.0 - initial release
// ============================================================================
module garage_gate_controller #(
    parameter int CAPACITY     = 20,
    parameter int TIMEOUT      = 16,
    parameter int CLOSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       car_passed,
    output logic       gate_open,
    output logic       dir_in,
    output logic [3:0] free_tens,
    output logic [3:0] free_ones,
    output logic       full
);

    localparam int              c_tmax     = (TIMEOUT > CLOSE_CYCLES) ? TIMEOUT : CLOSE_CYCLES;
    localparam int              c_tw       = $clog2(c_tmax + 1);
    localparam logic [c_tw-1:0] c_timeout  = c_tw'(TIMEOUT);
    localparam logic [c_tw-1:0] c_close    = c_tw'(CLOSE_CYCLES);
    localparam logic [3:0]      c_cap_tens = 4'(CAPACITY / 10);
    localparam logic [3:0]      c_cap_ones = 4'(CAPACITY % 10);
    localparam logic [6:0]      c_capacity = 7'(CAPACITY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_EXIT  = 2'd2,
        ST_CLOSE = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_tw-1:0] r_timer, w_timer_nxt, w_timer_inc;
    logic            r_last_exit, w_last_exit_nxt;
    logic [3:0]      w_tens_nxt, w_ones_nxt;
    logic            w_gate_nxt, w_dir_nxt, w_full_nxt;
    logic [6:0]      w_free_bin;
    logic            w_entry_ok, w_exit_ok, w_grant_exit;

    assign w_timer_inc = r_timer + 1'b1;
    assign w_free_bin  = (7'(free_tens) * 7'd10) + 7'(free_ones);
    assign w_entry_ok  = entry_req & ~full;
    assign w_exit_ok   = exit_req & (w_free_bin < c_capacity);
    // Contested grants go to whichever side was not served last
    assign w_grant_exit = w_exit_ok & (~w_entry_ok | ~r_last_exit);

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_last_exit_nxt = r_last_exit;
        w_tens_nxt      = free_tens;
        w_ones_nxt      = free_ones;
        case (r_state)
            ST_IDLE: begin
                if (w_entry_ok || w_exit_ok) begin
                    w_state_nxt     = w_grant_exit ? ST_EXIT : ST_ENTER;
                    w_last_exit_nxt = w_grant_exit;
                    w_timer_nxt     = '0;
                end
            end
            ST_ENTER, ST_EXIT: begin
                if (car_passed) begin
                    if (r_state == ST_ENTER) begin
                        if (free_ones == 4'd0) begin
                            w_ones_nxt = 4'd9;
                            w_tens_nxt = free_tens - 4'd1;
                        end else begin
                            w_ones_nxt = free_ones - 4'd1;
                        end
                    end else begin
                        if (free_ones == 4'd9) begin
                            w_ones_nxt = 4'd0;
                            w_tens_nxt = free_tens + 4'd1;
                        end else begin
                            w_ones_nxt = free_ones + 4'd1;
                        end
                    end
                    w_state_nxt = ST_CLOSE;
                    w_timer_nxt = '0;
                end else if (w_timer_inc == c_timeout) begin
                    w_state_nxt = ST_CLOSE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            ST_CLOSE: begin
                if (w_timer_inc == c_close) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Outputs are derived from next-state values so they are fully registered
    always_comb begin
        w_gate_nxt = (w_state_nxt == ST_ENTER) || (w_state_nxt == ST_EXIT);
        w_dir_nxt  = dir_in;
        if (w_state_nxt == ST_ENTER) begin
            w_dir_nxt = 1'b1;
        end else if (w_state_nxt == ST_EXIT) begin
            w_dir_nxt = 1'b0;
        end
        w_full_nxt = (w_tens_nxt == 4'd0) && (w_ones_nxt == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_last_exit <= 1'b0;
            gate_open   <= 1'b0;
            dir_in      <= 1'b0;
            free_tens   <= c_cap_tens;
            free_ones   <= c_cap_ones;
            full        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_last_exit <= w_last_exit_nxt;
            gate_open   <= w_gate_nxt;
            dir_in      <= w_dir_nxt;
            free_tens   <= w_tens_nxt;
            free_ones   <= w_ones_nxt;
            full        <= w_full_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_garage_gate_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_garage_gate_controller
// Brief    : Scoreboard bench for garage_gate_controller with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_garage_gate_controller;

    localparam int CAPACITY     = 20;
    localparam int TIMEOUT      = 16;
    localparam int CLOSE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       car_passed = 1'b0;
    logic       gate_open;
    logic       dir_in;
    logic [3:0] free_tens;
    logic [3:0] free_ones;
    logic       full;

    garage_gate_controller #(
        .CAPACITY    (CAPACITY),
        .TIMEOUT     (TIMEOUT),
        .CLOSE_CYCLES(CLOSE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .entry_req (entry_req),
        .exit_req  (exit_req),
        .car_passed(car_passed),
        .gate_open (gate_open),
        .dir_in    (dir_in),
        .free_tens (free_tens),
        .free_ones (free_ones),
        .full      (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gate;
        int dir;
        int tens;
        int ones;
        int full;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: occupancy as an integer, gate phases as remaining-cycle budgets
    int   m_free;
    bit   m_open;
    bit   m_dir;
    int   m_open_cycles;
    int   m_close_left;
    bit   m_last_exit;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_free        = CAPACITY;
        m_open        = 1'b0;
        m_dir         = 1'b0;
        m_open_cycles = 0;
        m_close_left  = 0;
        m_last_exit   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit ent, input bit ex, input bit cp);
        bit can_in, can_out, go_exit;
        if (m_open) begin
            m_open_cycles++;
            if (cp) begin
                m_free       = m_dir ? m_free - 1 : m_free + 1;
                m_open       = 1'b0;
                m_close_left = CLOSE_CYCLES;
            end else if (m_open_cycles == TIMEOUT) begin
                m_open       = 1'b0;
                m_close_left = CLOSE_CYCLES;
            end
        end else if (m_close_left > 0) begin
            m_close_left--;
        end else begin
            can_in  = ent && (m_free > 0);
            can_out = ex && (m_free < CAPACITY);
            if (can_in || can_out) begin
                go_exit       = (can_in && can_out) ? !m_last_exit : can_out;
                m_last_exit   = go_exit;
                m_open        = 1'b1;
                m_dir         = !go_exit;
                m_open_cycles = 0;
            end
        end
    endtask

    task automatic step(input bit ent, input bit ex, input bit cp);
        exp_t e;
        @(negedge clk);
        entry_req  = ent;
        exit_req   = ex;
        car_passed = cp;
        model_step(ent, ex, cp);
        e.gate = int'(m_open);
        e.dir  = int'(m_dir);
        e.tens = m_free / 10;
        e.ones = m_free % 10;
        e.full = (m_free == 0) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // Request until granted, hold wait_n cycles, pulse car_passed, then let the gate close
    task automatic do_passage(input bit ent, input bit ex, input int wait_n);
        int k;
        k = 0;
        while (!m_open && k < 40) begin
            step(ent, ex, 1'b0);
            k++;
        end
        repeat (wait_n) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        k = 0;
        while ((m_open || m_close_left > 0) && k < 40) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gate_open", int'(gate_open), e.gate);
                check("dir_in",    int'(dir_in),    e.dir);
                check("free_tens", int'(free_tens), e.tens);
                check("free_ones", int'(free_ones), e.ones);
                check("full",      int'(full),      e.full);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int guard;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_gate", int'(gate_open), 0);
        check("reset_tens", int'(free_tens), 2);
        check("reset_ones", int'(free_ones), 0);
        check("reset_full", int'(full), 0);
        rst_n = 1'b1;

        // Exit alone on an empty garage is never granted
        repeat (5) step(1'b0, 1'b1, 1'b0);

        // Single entry, passage three cycles after opening
        do_passage(1'b1, 1'b0, 2);
        settle();
        check("entry_tens", int'(free_tens), 1);
        check("entry_ones", int'(free_ones), 9);

        // Bring free count to 15, then contested requests alternate exit/entry
        repeat (4) do_passage(1'b1, 1'b0, 1);
        repeat (4) do_passage(1'b1, 1'b1, 1);
        settle();
        check("rr_tens", int'(free_tens), 1);
        check("rr_ones", int'(free_ones), 5);

        // Fill the garage, then entry is refused; one exit frees a space
        repeat (15) do_passage(1'b1, 1'b0, 0);
        settle();
        check("full_flag", int'(full), 1);
        repeat (20) step(1'b1, 1'b0, 1'b0);
        do_passage(1'b0, 1'b1, 1);
        settle();
        check("one_free_ones", int'(free_ones), 1);
        check("one_free_full", int'(full), 0);

        // Timeout with no passage; car_passed while closing is ignored
        step(1'b1, 1'b0, 1'b0);
        repeat (TIMEOUT) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (CLOSE_CYCLES + 2) step(1'b0, 1'b0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom % 2), 1'($urandom % 2), ($urandom % 4) == 0);
        end
        repeat (TIMEOUT + CLOSE_CYCLES + 2) step(1'b0, 1'b0, 1'b0);

        // Steer to free=07, open for exit, then reset mid-open
        guard = 0;
        while (m_free != 7 && guard < 100) begin
            if (m_free > 7) do_passage(1'b1, 1'b0, 0);
            else            do_passage(1'b0, 1'b1, 0);
            guard++;
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        settle();
        check("pre_reset_gate", int'(gate_open), 1);
        check("pre_reset_ones", int'(free_ones), 7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_gate", int'(gate_open), 0);
        check("async_tens", int'(free_tens), 2);
        check("async_ones", int'(free_ones), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) step(1'b0, 1'b1, 1'b0);
        do_passage(1'b1, 1'b0, 0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/garage_gate_controller.md
# garage_gate_controller

Sequencing controller for a single-lane car-park gate shared by entering and exiting cars. It arbitrates entry and exit requests, opens and times the gate, and confirms each passage with a sensor pulse. It keeps the free-space count directly in BCD and drives the tens/ones nibbles that feed the two seven-segment decoders on the garage display.

## Interface
Parameters:
- CAPACITY, default 20: total spaces, legal range 1..99; also the free count at reset.
- TIMEOUT, default 16: maximum open cycles waiting for a passage before the gate closes uncounted.
- CLOSE_CYCLES, default 4: gate travel time; no new grant during this time.

Ports:
- clk  in  1  system clock, rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- entry_req  in  1  level; car present at the outer (entry) sensor.
- exit_req  in  1  level; car present at the inner (exit) sensor.
- car_passed  in  1  one-cycle pulse from the under-gate loop; the car has cleared the gate.
- gate_open  out  1  gate motor command; 1 = open.
- dir_in  out  1  lane direction while open; 1 = inbound, 0 = outbound.
- free_tens  out  4  BCD tens digit of free spaces, to the decoder.
- free_ones  out  4  BCD ones digit of free spaces, to the decoder.
- full  out  1  free count is 00.

## Operation
- All outputs are registered.
- States: IDLE, ENTER, EXIT, CLOSE.
- **IDLE** (gate closed):
  - Entry eligible: entry_req=1 and full=0.
  - Exit eligible: exit_req=1 and free count < CAPACITY.
  - Only one eligible: grant it (ENTER or EXIT).
  - Both eligible: round-robin on a last_grant bit. Reset value of last_grant favours exit first, so the first contested grant goes to exit.
  - Ineligible requests are ignored, not queued.
- **ENTER / EXIT**: gate_open=1; dir_in=1 in ENTER, 0 in EXIT. A timer counts open cycles.
  - car_passed=1: free count is updated (ENTER decrements, EXIT increments), then go to CLOSE.
  - Timer reaches TIMEOUT without car_passed: go to CLOSE, count unchanged.
- **CLOSE**: gate_open=0 for exactly CLOSE_CYCLES cycles, then IDLE. dir_in holds its last value.
- car_passed in IDLE or CLOSE is ignored; the count is unchanged.
- Free count is held as two BCD digits.
  - Decrement: ones 0 → 9 with tens−1.
  - Increment: ones 9 → 0 with tens+1.
  - The count never leaves 00..CAPACITY; the eligibility rules guarantee this.
  - full = (free_tens==0 and free_ones==0).
- Timer width: clog2(max(TIMEOUT, CLOSE_CYCLES)+1) bits, shared between the open and close phases, cleared on every state change.

## Timing
- Reset (async assert, sync release):
  - State IDLE, gate_open=0, dir_in=0, last_grant=exit-favoured, timer=0.
  - free_tens=CAPACITY/10, free_ones=CAPACITY%10, full=0.
- Grant latency: a request sampled at edge N in IDLE gives gate_open=1 (and dir_in) after edge N.
- Passage: car_passed sampled at edge M in ENTER/EXIT.
  - After edge M: new free digits and full are visible, and gate_open=0.
  - IDLE is re-entered CLOSE_CYCLES edges later.
  - Next grant possible at the edge after that.
- Timeout: gate_open falls after the TIMEOUT-th open edge, i.e. the gate is open for exactly TIMEOUT cycles.
- car_passed on the same edge the timer expires: counted as a passage.
- Requests changing while not in IDLE: no effect; re-evaluated only in IDLE.
- Reset mid-open: gate_open drops immediately (async) and the count returns to CAPACITY. This is intended; there is no occupancy memory across reset.

## Test plan
- Reset, CAPACITY=20 → free_tens=2, free_ones=0, full=0, gate_open=0. Exit_req alone is not granted (garage empty).
- Entry_req, then car_passed 3 cycles after gate_open → dir_in=1, free 20→19 (tens=1, ones=9). Gate closed for 4 cycles before the next grant.
- Simultaneous entry_req and exit_req at free=15 → exit granted first (free 16). Then entry is granted (free 15), strictly alternating over 4 passages.
- CAPACITY=20 with 20 entries → free=00, full=1. Further entry_req is never granted. One exit → free=01, full=0.
- Entry granted, no car_passed → gate_open high exactly 16 cycles, free unchanged. car_passed pulsed during CLOSE is ignored.
- rst_n asserted during EXIT with free=07 → gate_open=0 asynchronously. After release, free=20 and state IDLE.
